// File: rtl/demux1x2_stream.sv
// 1-to-2 valid/ready stream demultiplexer with packet-locked routing.
// Each output channel owns a one-entry register slice that drains independently.
module demux1x2_stream #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sel,
    input  logic                  in_last,
    output logic                  out0_valid,
    input  logic                  out0_ready,
    output logic [DATA_WIDTH-1:0] out0_data,
    output logic                  out0_last,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic                  out1_last,
    output logic                  sel_err
);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e                state_q, state_d;
    logic                  locked_sel_q, locked_sel_d;
    logic                  sel_err_q, sel_err_d;
    logic                  out0_valid_q, out0_valid_d;
    logic                  out1_valid_q, out1_valid_d;
    logic [DATA_WIDTH-1:0] out0_data_q, out1_data_q;
    logic                  out0_last_q, out1_last_q;

    logic route;
    logic accept;
    logic load0, load1;

    always_comb begin
        state_d      = state_q;
        locked_sel_d = locked_sel_q;

        // Only the routed channel can stall the input; the other may be full.
        route    = (state_q == StLock) ? locked_sel_q : in_sel;
        in_ready = route ? (~out1_valid_q | out1_ready) : (~out0_valid_q | out0_ready);
        accept   = in_valid & in_ready;
        load0    = accept & ~route;
        load1    = accept & route;

        if (accept) begin
            case (state_q)
                StIdle: begin
                    if (!in_last) begin
                        state_d      = StLock;
                        locked_sel_d = in_sel;
                    end
                end
                StLock: begin
                    if (in_last) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        sel_err_d = accept && (state_q == StLock) && (in_sel != locked_sel_q);

        // A reload in the same cycle as a drain keeps the slot full.
        out0_valid_d = load0 | (out0_valid_q & ~out0_ready);
        out1_valid_d = load1 | (out1_valid_q & ~out1_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            locked_sel_q <= 1'b0;
            sel_err_q    <= 1'b0;
            out0_valid_q <= 1'b0;
            out1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            locked_sel_q <= locked_sel_d;
            sel_err_q    <= sel_err_d;
            out0_valid_q <= out0_valid_d;
            out1_valid_q <= out1_valid_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out0_data_q <= '0;
            out0_last_q <= 1'b0;
            out1_data_q <= '0;
            out1_last_q <= 1'b0;
        end else begin
            if (load0) begin
                out0_data_q <= in_data;
                out0_last_q <= in_last;
            end
            if (load1) begin
                out1_data_q <= in_data;
                out1_last_q <= in_last;
            end
        end
    end

    assign out0_valid = out0_valid_q;
    assign out0_data  = out0_data_q;
    assign out0_last  = out0_last_q;
    assign out1_valid = out1_valid_q;
    assign out1_data  = out1_data_q;
    assign out1_last  = out1_last_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_demux1x2_stream.sv
// Scoreboard bench for demux1x2_stream: directed packets push expected beats per
// channel, a negedge monitor pops and compares on every output handshake.
module tb_demux1x2_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_sel = 1'b0;
    logic        in_last = 1'b0;
    logic        out0_valid, out1_valid;
    logic        out0_ready = 1'b1;
    logic        out1_ready = 1'b1;
    logic [15:0] out0_data, out1_data;
    logic        out0_last, out1_last;
    logic        sel_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];

    demux1x2_stream #(.DATA_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out0_data (out0_data),
        .out0_last (out0_last),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out1_data (out1_data),
        .out1_last (out1_last),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one beat (called at posedge+1); ch is the hand-computed destination,
    // err the expected sel_err level in the cycle after acceptance.
    task automatic send(input int ch, input logic [15:0] d, input logic s, input logic l,
                        input logic err);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept timeout: data %0h never accepted, expected within 20 cycles", d);
            in_valid = 1'b0;
            return;
        end
        if (ch == 0) q0.push_back({l, d});
        else         q1.push_back({l, d});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("sel_err", sel_err, err);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        if (!reset) begin
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL out0 unexpected beat: got %0h expected none", out0_data);
                end else begin
                    e = q0.pop_front();
                    chk("out0_data", out0_data, e[15:0]);
                    chk("out0_last", out0_last, e[16]);
                end
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL out1 unexpected beat: got %0h expected none", out1_data);
                end else begin
                    e = q1.pop_front();
                    chk("out1_data", out1_data, e[15:0]);
                    chk("out1_last", out1_last, e[16]);
                end
            end
        end
    end

    initial begin
        // Reset release with no input traffic
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst out0_valid", out0_valid, 0);
        chk("rst out1_valid", out1_valid, 0);
        chk("rst out0_data", out0_data, 0);
        chk("rst out1_data", out1_data, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst sel_err", sel_err, 0);
        tick();

        // Single-beat packet to out1
        send(1, 16'hA5A5, 1'b1, 1'b1, 1'b0);
        chk("single out1_valid", out1_valid, 1);
        chk("single out1_data", out1_data, 16'hA5A5);
        chk("single out0_valid", out0_valid, 0);

        // Four-beat packet locked to out0, sel toggling mid-packet
        send(0, 16'd1, 1'b0, 1'b0, 1'b0);
        send(0, 16'd2, 1'b1, 1'b0, 1'b1);
        send(0, 16'd3, 1'b0, 1'b0, 1'b0);
        send(0, 16'd4, 1'b1, 1'b1, 1'b1);
        chk("pkt out1_valid", out1_valid, 0);
        tick();
        chk("sel_err one cycle", sel_err, 0);

        // Backpressure on out0 must not block a beat headed to out1
        out0_ready = 1'b0;
        send(0, 16'h1111, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h2222; in_last = 1'b1;
        #1;
        chk("bp in_ready sel0", in_ready, 0);
        chk("bp out0_data hold", out0_data, 16'h1111);
        in_sel = 1'b1;
        #1;
        chk("bp in_ready sel1", in_ready, 1);
        send(1, 16'h3333, 1'b1, 1'b1, 1'b0);
        chk("bp out0_data still", out0_data, 16'h1111);
        chk("bp out1_data", out1_data, 16'h3333);
        out0_ready = 1'b1;
        tick();

        // Drain and reload of out1 in the same cycle
        out1_ready = 1'b0;
        send(1, 16'h5555, 1'b1, 1'b1, 1'b0);
        out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h6666; in_last = 1'b1;
        #1;
        chk("reload in_ready", in_ready, 1);
        send(1, 16'h6666, 1'b1, 1'b1, 1'b0);
        chk("reload out1_valid", out1_valid, 1);
        chk("reload out1_data", out1_data, 16'h6666);
        tick();

        // Reset in the middle of a packet to out1
        send(1, 16'h0A01, 1'b1, 1'b0, 1'b0);
        send(1, 16'h0A02, 1'b1, 1'b0, 1'b0);
        out1_ready = 1'b0;
        q1.delete();  // the buffered beat is discarded by reset
        #2 reset = 1'b1;
        #1;
        chk("midrst out1_valid", out1_valid, 0);
        tick();
        reset = 1'b0;
        out1_ready = 1'b1;
        tick();
        send(0, 16'h0B01, 1'b0, 1'b1, 1'b0);
        chk("postrst out0_valid", out0_valid, 1);
        chk("postrst out1_valid", out1_valid, 0);
        chk("postrst out0_data", out0_data, 16'h0B01);

        for (int i = 0; i < 20; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            tick();
        end
        chk("scoreboard drained", q0.size() + q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
